// File: rtl/dataflow_bus_fabric.sv
// Register/bus datapath fabric: wired-OR buses with hold latches, per-register load/inc/dec
// and registered diagnostic flags. Optional bus merging is enabled by defining PASS_GATE_EN.
module dataflow_bus_fabric #(
  parameter int DATA_WIDTH = 8,
  parameter int REG_COUNT  = 6,
  parameter int BUS_COUNT  = 4,
  parameter logic [DATA_WIDTH-1:0] REG_RESET = {DATA_WIDTH{1'b0}}
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [REG_COUNT*BUS_COUNT-1:0]  drive_en,
  input  logic [REG_COUNT*BUS_COUNT-1:0]  load_en,
  input  logic [REG_COUNT-1:0]            inc_en,
  input  logic [REG_COUNT-1:0]            dec_en,
  input  logic [BUS_COUNT-1:0]            ext_drive_en,
  input  logic [DATA_WIDTH-1:0]           ext_data,
  input  logic [BUS_COUNT-2:0]            pass_en,
  output logic [BUS_COUNT*DATA_WIDTH-1:0] bus_out,
  output logic [REG_COUNT*DATA_WIDTH-1:0] reg_out,
  output logic [BUS_COUNT-1:0]            bus_contention,
  output logic [REG_COUNT-1:0]            load_conflict
);

  localparam int CW = $clog2((REG_COUNT + 1) * BUS_COUNT + 1) + 1;
  localparam logic [DATA_WIDTH-1:0] ONE = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

  logic [DATA_WIDTH-1:0] regs_r     [REG_COUNT];
  logic [DATA_WIDTH-1:0] hold_r     [BUS_COUNT];
  logic [BUS_COUNT-1:0]  contention_r;
  logic [REG_COUNT-1:0]  conflict_r;

  logic [DATA_WIDTH-1:0] raw_val_s  [BUS_COUNT];
  logic [CW-1:0]         raw_cnt_s  [BUS_COUNT];
  logic [DATA_WIDTH-1:0] grp_val_s  [BUS_COUNT];
  logic [CW-1:0]         grp_cnt_s  [BUS_COUNT];
  logic [DATA_WIDTH-1:0] bus_s      [BUS_COUNT];
  logic [DATA_WIDTH-1:0] next_s     [REG_COUNT];
  logic [REG_COUNT-1:0]  conflict_s;
  logic [BUS_COUNT-1:0]  contention_s;

  // Per-bus wired-OR of every active driver and a count of those drivers
  always_comb begin
    for (int b = 0; b < BUS_COUNT; b++) begin
      raw_val_s[b] = ext_data & {DATA_WIDTH{ext_drive_en[b]}};
      raw_cnt_s[b] = CW'(ext_drive_en[b]);
      for (int r = 0; r < REG_COUNT; r++) begin
        raw_val_s[b] = raw_val_s[b] | (regs_r[r] & {DATA_WIDTH{drive_en[r*BUS_COUNT+b]}});
        raw_cnt_s[b] = raw_cnt_s[b] + CW'(drive_en[r*BUS_COUNT+b]);
      end
    end
  end

`ifdef PASS_GATE_EN
  logic linked_s;
  int   lo_s;
  int   hi_s;

  // Buses b and c share a net when every pass gate between them is closed
  always_comb begin
    linked_s = 1'b0;
    lo_s     = 0;
    hi_s     = 0;
    for (int b = 0; b < BUS_COUNT; b++) begin
      grp_val_s[b] = {DATA_WIDTH{1'b0}};
      grp_cnt_s[b] = {CW{1'b0}};
      for (int c = 0; c < BUS_COUNT; c++) begin
        lo_s     = (b < c) ? b : c;
        hi_s     = (b < c) ? c : b;
        linked_s = 1'b1;
        for (int k = 0; k < BUS_COUNT - 1; k++) begin
          linked_s = linked_s & (((k >= lo_s) && (k < hi_s)) ? pass_en[k] : 1'b1);
        end
        grp_val_s[b] = grp_val_s[b] | (raw_val_s[c] & {DATA_WIDTH{linked_s}});
        grp_cnt_s[b] = grp_cnt_s[b] + (raw_cnt_s[c] & {CW{linked_s}});
      end
    end
  end
`else
  logic unused_pass_s;
  assign unused_pass_s = ^pass_en;
  assign grp_val_s     = raw_val_s;
  assign grp_cnt_s     = raw_cnt_s;
`endif

  // Visible bus value: driven group value, else this bus's hold latch
  always_comb begin
    for (int b = 0; b < BUS_COUNT; b++) begin
      bus_s[b]        = (grp_cnt_s[b] != {CW{1'b0}}) ? grp_val_s[b] : hold_r[b];
      contention_s[b] = (grp_cnt_s[b] > CW'(1));
      bus_out[b*DATA_WIDTH +: DATA_WIDTH] = bus_s[b];
    end
  end

  logic [DATA_WIDTH-1:0] ld_val_s;
  logic [CW-1:0]         ld_cnt_s;

  // Next register value: load beats inc/dec; inc and dec together cancel
  always_comb begin
    ld_val_s = {DATA_WIDTH{1'b0}};
    ld_cnt_s = {CW{1'b0}};
    for (int r = 0; r < REG_COUNT; r++) begin
      ld_val_s = {DATA_WIDTH{1'b0}};
      ld_cnt_s = {CW{1'b0}};
      for (int b = 0; b < BUS_COUNT; b++) begin
        ld_val_s = ld_val_s | (bus_s[b] & {DATA_WIDTH{load_en[r*BUS_COUNT+b]}});
        ld_cnt_s = ld_cnt_s + CW'(load_en[r*BUS_COUNT+b]);
      end
      conflict_s[r] = (ld_cnt_s > CW'(1)) | (inc_en[r] & dec_en[r]);
      if (ld_cnt_s != {CW{1'b0}}) begin
        next_s[r] = ld_val_s;
      end else if (inc_en[r] && !dec_en[r]) begin
        next_s[r] = regs_r[r] + ONE;
      end else if (dec_en[r] && !inc_en[r]) begin
        next_s[r] = regs_r[r] - ONE;
      end else begin
        next_s[r] = regs_r[r];
      end
      reg_out[r*DATA_WIDTH +: DATA_WIDTH] = regs_r[r];
    end
  end

  // State update: registers, hold latches and one-cycle diagnostic flags
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < REG_COUNT; r++) regs_r[r] <= REG_RESET;
      for (int b = 0; b < BUS_COUNT; b++) hold_r[b] <= REG_RESET;
      contention_r <= {BUS_COUNT{1'b0}};
      conflict_r   <= {REG_COUNT{1'b0}};
    end else begin
      for (int r = 0; r < REG_COUNT; r++) regs_r[r] <= next_s[r];
      for (int b = 0; b < BUS_COUNT; b++) begin
        hold_r[b] <= (grp_cnt_s[b] != {CW{1'b0}}) ? grp_val_s[b] : hold_r[b];
      end
      contention_r <= contention_s;
      conflict_r   <= conflict_s;
    end
  end

  assign bus_contention = contention_r;
  assign load_conflict  = conflict_r;

endmodule

// File: tb/tb_dataflow_bus_fabric.sv
// Directed self-checking bench for dataflow_bus_fabric at default parameters.
module tb_dataflow_bus_fabric;

  logic        clk;
  logic        rst;
  logic [23:0] drive_en;
  logic [23:0] load_en;
  logic [5:0]  inc_en;
  logic [5:0]  dec_en;
  logic [3:0]  ext_drive_en;
  logic [7:0]  ext_data;
  logic [2:0]  pass_en;
  logic [31:0] bus_out;
  logic [47:0] reg_out;
  logic [3:0]  bus_contention;
  logic [5:0]  load_conflict;

  int total = 0;
  int bad   = 0;

  dataflow_bus_fabric dut (
    .clk(clk), .rst(rst), .drive_en(drive_en), .load_en(load_en),
    .inc_en(inc_en), .dec_en(dec_en), .ext_drive_en(ext_drive_en),
    .ext_data(ext_data), .pass_en(pass_en), .bus_out(bus_out),
    .reg_out(reg_out), .bus_contention(bus_contention), .load_conflict(load_conflict)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] busv(input int b);
    return bus_out[b*8 +: 8];
  endfunction

  function automatic logic [7:0] regv(input int r);
    return reg_out[r*8 +: 8];
  endfunction

  function automatic int di(input int r, input int b);
    return r * 4 + b;
  endfunction

  task automatic clear_en();
    drive_en     = 24'h0;
    load_en      = 24'h0;
    inc_en       = 6'h0;
    dec_en       = 6'h0;
    ext_drive_en = 4'h0;
    ext_data     = 8'h00;
    pass_en      = 3'b000;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Load register r with value v via external data on bus b
  task automatic preset(input int r, input int b, input logic [7:0] v);
    clear_en();
    ext_data         = v;
    ext_drive_en[b]  = 1'b1;
    load_en[di(r,b)] = 1'b1;
    tick();
    clear_en();
  endtask

  initial begin
    // Reset with every enable asserted
    rst = 1'b1;
    drive_en = 24'hFFFFFF; load_en = 24'hFFFFFF; inc_en = 6'h3F; dec_en = 6'h3F;
    ext_drive_en = 4'hF; ext_data = 8'hFF; pass_en = 3'b111;
    tick();
    tick();
    rst = 1'b0;
    clear_en();
    #1;
    check_val("reset_regs", reg_out, 48'h0);
    check_val("reset_bus", bus_out, 32'h0);
    check_val("reset_cont", bus_contention, 4'h0);
    check_val("reset_conf", load_conflict, 6'h0);

    // Register-to-register move in one cycle
    preset(0, 0, 8'h5A);
    check_val("preset_r0", regv(0), 8'h5A);
    drive_en[di(0,1)] = 1'b1;
    load_en[di(3,1)]  = 1'b1;
    #1;
    check_val("move_bus1", busv(1), 8'h5A);
    tick();
    check_val("move_r3", regv(3), 8'h5A);
    check_val("move_nocont", bus_contention, 4'h0);
    check_val("move_noconf", load_conflict, 6'h0);
    clear_en();

    // Bus hold after ext drive goes away
    ext_data = 8'h3C; ext_drive_en[2] = 1'b1;
    #1;
    check_val("hold_drv", busv(2), 8'h3C);
    tick();
    clear_en();
    #1;
    check_val("hold_1", busv(2), 8'h3C);
    tick();
    tick();
    check_val("hold_3", busv(2), 8'h3C);
    load_en[di(4,2)] = 1'b1;
    tick();
    check_val("hold_r4", regv(4), 8'h3C);
    clear_en();

    // Increment/decrement wrap and inc+dec conflict
    preset(5, 3, 8'hFF);
    check_val("preset_r5", regv(5), 8'hFF);
    inc_en[5] = 1'b1;
    tick();
    check_val("inc_wrap", regv(5), 8'h00);
    clear_en(); dec_en[5] = 1'b1;
    tick();
    check_val("dec_wrap", regv(5), 8'hFF);
    clear_en(); inc_en[5] = 1'b1; dec_en[5] = 1'b1;
    tick();
    check_val("incdec_hold", regv(5), 8'hFF);
    check_val("incdec_conf", load_conflict, 6'b100000);
    clear_en();
    tick();
    check_val("conf_pulse", load_conflict, 6'h0);

    // Contention on bus0
    preset(1, 0, 8'h0F);
    preset(2, 0, 8'hF0);
    check_val("preset_r1", regv(1), 8'h0F);
    check_val("preset_r2", regv(2), 8'hF0);
    drive_en[di(1,0)] = 1'b1;
    drive_en[di(2,0)] = 1'b1;
    #1;
    check_val("cont_bus0", busv(0), 8'hFF);
    tick();
    check_val("cont_flag", bus_contention, 4'b0001);
    clear_en();
    tick();
    check_val("cont_pulse", bus_contention, 4'h0);
    check_val("cont_hold0", busv(0), 8'hFF);

    // Load from two held buses: OR of both, flagged as conflict
    load_en[di(3,1)] = 1'b1;
    load_en[di(3,2)] = 1'b1;
    tick();
    check_val("multi_load", regv(3), 8'h7E);
    check_val("multi_conf", load_conflict, 6'b001000);
    clear_en();

    // Load wins over increment
    load_en[di(4,1)] = 1'b1;
    inc_en[4] = 1'b1;
    tick();
    check_val("load_over_inc", regv(4), 8'h5A);
    check_val("load_inc_noconf", load_conflict, 6'h0);
    clear_en();

    // Load-to-self via bus3 leaves the register unchanged
    drive_en[di(3,3)] = 1'b1;
    load_en[di(3,3)]  = 1'b1;
    tick();
    check_val("self_load", regv(3), 8'h7E);
    clear_en();
    #1;
    check_val("self_hold3", busv(3), 8'h7E);

    // Pass gate between bus0 and bus1
    preset(0, 0, 8'h81);
    drive_en[di(0,0)] = 1'b1;
    pass_en[0] = 1'b1;
    #1;
    check_val("pass_bus0", busv(0), 8'h81);
`ifdef PASS_GATE_EN
    check_val("pass_bus1", busv(1), 8'h81);
`else
    check_val("pass_bus1", busv(1), 8'h5A);
`endif
    tick();
    clear_en();
    #1;
`ifdef PASS_GATE_EN
    check_val("pass_hold1", busv(1), 8'h81);
`else
    check_val("pass_hold1", busv(1), 8'h5A);
`endif

    // Mid-operation reset discards pending enables
    inc_en = 6'h3F; drive_en[di(1,0)] = 1'b1; drive_en[di(2,0)] = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    clear_en();
    #1;
    check_val("mid_rst_regs", reg_out, 48'h0);
    check_val("mid_rst_bus", bus_out, 32'h0);
    check_val("mid_rst_cont", bus_contention, 4'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
